// File: rtl/tff_bank_multi.sv
// tff_bank_multi: WIDTH independent storage channels sharing clock, reset,
// enable and a run-time mode select (D / T / JK / SR). Provides a registered
// complement, a registered change-detect pulse and a sticky illegal-SR flag.
module tff_bank_multi #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             changed,
  output logic             sr_err
);

  typedef enum logic [1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  // Next value of one channel given the mode, its current state and inputs.
  // The SR illegal code (s=r=1) holds the channel; flagging is done globally.
  function automatic logic next_bit(input mode_e m, input logic cur,
                                    input logic pa, input logic pb);
    logic nb;
    nb = cur;
    case (m)
      MODE_D:  nb = pa;
      MODE_T:  nb = cur ^ pa;
      MODE_JK: begin
        case ({pa, pb})
          2'b00:   nb = cur;
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          2'b11:   nb = ~cur;
          default: nb = cur;
        endcase
      end
      MODE_SR: begin
        case ({pa, pb})
          2'b00:   nb = cur;
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          2'b11:   nb = cur;
          default: nb = cur;
        endcase
      end
      default: nb = cur;
    endcase
    return nb;
  endfunction

  mode_e            mode_s;
  logic             sr_illegal_s;
  logic [WIDTH-1:0] q_d, q_q;
  logic [WIDTH-1:0] qn_d, qn_q;
  logic             changed_d, changed_q;
  logic             sr_err_d, sr_err_q;

  assign mode_s = mode_e'(mode);

  // Next-state computation for all channels and the status flags.
  always_comb begin
    q_d          = q_q;
    qn_d         = qn_q;
    changed_d    = 1'b0;
    sr_err_d     = sr_err_q;
    sr_illegal_s = (mode_s == MODE_SR) && (|(a & b));

    if (en) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        q_d[i] = next_bit(mode_s, q_q[i], a[i], b[i]);
      end
    end else begin
      q_d = q_q;
    end

    // Complement is its own flop so qn never depends combinationally on q.
    qn_d      = ~q_d;
    changed_d = (q_d != q_q);

    // A new illegal SR event beats a simultaneous clear.
    if (en && sr_illegal_s) begin
      sr_err_d = 1'b1;
    end else if (clr_err) begin
      sr_err_d = 1'b0;
    end else begin
      sr_err_d = sr_err_q;
    end
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= RESET_VAL;
      qn_q      <= ~RESET_VAL;
      changed_q <= 1'b0;
      sr_err_q  <= 1'b0;
    end else begin
      q_q       <= q_d;
      qn_q      <= qn_d;
      changed_q <= changed_d;
      sr_err_q  <= sr_err_d;
    end
  end

  assign q       = q_q;
  assign qn      = qn_q;
  assign changed = changed_q;
  assign sr_err  = sr_err_q;

endmodule

// File: tb/tb_tff_bank_multi.sv
// Testbench for tff_bank_multi (WIDTH=4, RESET_VAL=4'b0101): directed vector
// table, a short hand-written sequence, then random stimulus vs. a model.
module tb_tff_bank_multi;

  localparam int unsigned    W  = 4;
  localparam logic [W-1:0]   RV = 4'b0101;

  logic         clk;
  logic         reset;
  logic         en;
  logic [1:0]   mode;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         clr_err;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         changed;
  logic         sr_err;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         clr;
    logic [W-1:0] eq;
    logic         ech;
    logic         eerr;
  } vec_t;

  vec_t tbl[$];

  tff_bank_multi #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .a(a), .b(b),
    .clr_err(clr_err), .q(q), .qn(qn), .changed(changed), .sr_err(sr_err)
  );

  // 100 ns clock.
  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", nm, got, exp);
    end
  endtask

  task automatic push(input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] va, input logic [W-1:0] vb, input logic c,
                      input logic [W-1:0] eq, input logic ech, input logic eerr);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.a = va; v.b = vb; v.clr = c;
    v.eq = eq; v.ech = ech; v.eerr = eerr;
    tbl.push_back(v);
  endtask

  // Drive inputs, take one edge, sample 1 ns later.
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input logic [W-1:0] va, input logic [W-1:0] vb, input logic c);
    reset = r; en = e; mode = m; a = va; b = vb; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [W-1:0] eq,
                         input logic ech, input logic eerr);
    chk({tag, ".q"}, q, eq);
    chk({tag, ".qn"}, qn, ~eq);
    chk({tag, ".changed"}, {3'b000, changed}, {3'b000, ech});
    chk({tag, ".sr_err"}, {3'b000, sr_err}, {3'b000, eerr});
  endtask

  // Reference model state.
  logic [W-1:0] mq;
  logic         mch;
  logic         merr;

  // Characteristic-equation model, evaluated on whole vectors.
  task automatic model_edge(input logic r, input logic e, input logic [1:0] m,
                            input logic [W-1:0] va, input logic [W-1:0] vb, input logic c);
    logic [W-1:0] nq;
    if (r) begin
      mq = RV; mch = 1'b0; merr = 1'b0;
    end else begin
      nq = mq;
      if (e) begin
        if (m == 2'd0)      nq = va;
        else if (m == 2'd1) nq = mq ^ va;
        else if (m == 2'd2) nq = (va & ~mq) | (~vb & mq);
        else                nq = (va & ~vb) | (mq & ~(vb & ~va));
      end
      mch = (nq != mq);
      if (e && m == 2'd3 && ((va & vb) != 4'b0000)) merr = 1'b1;
      else if (c)                                    merr = 1'b0;
      mq = nq;
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; a = 4'b0000; b = 4'b0000; clr_err = 1'b0;

    //    rst  en    mode   a        b        clr    q        ch    err
    // Reset then T toggle
    push(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0);
    push(1'b1, 1'b0, 2'd0, 4'b0000, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b0000, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b1010, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b0101, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b1010, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b0101, 1'b1, 1'b0);
    // JK all four codes from 0101: toggle, set, clear, hold
    push(1'b0, 1'b1, 2'd2, 4'b1100, 4'b1010, 1'b0, 4'b1101, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 1'b0, 4'b1101, 1'b0, 1'b0);
    // SR illegal from 0000
    push(1'b0, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd3, 4'b1011, 4'b0011, 1'b0, 4'b1000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      push(1'b0, 1'b0, 2'd3, 4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'd3, 4'b0011, 4'b0011, 1'b1, 4'b1000, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'd3, 4'b0000, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0);
    // Enable gating and D
    for (int i = 0; i < 3; i++)
      push(1'b0, 1'b0, 2'd0, 4'b1001, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0);
    push(1'b0, 1'b1, 2'd0, 4'b1001, 4'b0000, 1'b0, 4'b1001, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd0, 4'b1001, 4'b0000, 1'b0, 4'b1001, 1'b0, 1'b0);
    // Reset mid-operation with q=1010, sr_err=1
    push(1'b0, 1'b1, 2'd0, 4'b1010, 4'b0000, 1'b0, 4'b1010, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd3, 4'b0001, 4'b0001, 1'b0, 4'b1010, 1'b0, 1'b1);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b0101, 1'b1, 1'b1);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b1010, 1'b1, 1'b1);
    push(1'b1, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b0101, 1'b0, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b1010, 1'b1, 1'b0);
    push(1'b0, 1'b1, 2'd1, 4'b1111, 4'b0000, 1'b0, 4'b0101, 1'b1, 1'b0);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].clr);
      chk_all($sformatf("vec%0d", i), tbl[i].eq, tbl[i].ech, tbl[i].eerr);
    end

    // Hand sequence: clr_err works with en=0, q untouched.
    step(1'b0, 1'b1, 2'd3, 4'b0001, 4'b0001, 1'b0);
    chk_all("hs_set", 4'b0101, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd3, 4'b0001, 4'b0001, 1'b1);
    chk_all("hs_clr_en0", 4'b0101, 1'b0, 1'b0);
    // Hand sequence: reset with different RESET_VAL target still gives changed=0.
    step(1'b0, 1'b1, 2'd0, 4'b1110, 4'b0000, 1'b0);
    chk_all("hs_d", 4'b1110, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd0, 4'b0000, 4'b0000, 1'b0);
    chk_all("hs_rst", 4'b0101, 1'b0, 1'b0);

    // Randomised phase against the model, starting from the known state.
    mq = 4'b0101; mch = 1'b0; merr = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic         r, e, c;
      logic [1:0]   m;
      logic [W-1:0] va, vb;
      r  = ($urandom_range(0, 31) == 0);
      e  = ($urandom_range(0, 3) != 0);
      m  = 2'($urandom_range(0, 3));
      va = 4'($urandom);
      vb = 4'($urandom);
      c  = ($urandom_range(0, 7) == 0);
      step(r, e, m, va, vb, c);
      model_edge(r, e, m, va, vb, c);
      chk_all($sformatf("rnd%0d", n), mq, mch, merr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
